crono_temp_core: RTL
====================

Name: crono_temp_core

Overview:
Parametrised stopwatch/countdown-timer core, the next generation of the board's single-mode 4-digit stopwatch/timer.
- Counts in packed BCD, so digits drive the 7-seg decoders directly; no binary-to-digit splitter.
- Has explicit IDLE/RUN/PAUSE/DONE control, a BCD limit for up-count, and a done pulse.
- Sits between the debounced pushbutton/switch layer and the per-digit 7-seg decoders.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, count rate; DIV = CLK_HZ/TICK_HZ clocks per tick. Elaboration error if DIV < 2.
- DIGITS, 4, number of BCD digits; counter width W = 4*DIGITS.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; clock clk.
- mode  in  1  0 = stopwatch (count up to limit), 1 = timer (count down to 0); sampled only on start from IDLE.
- start_stop  in  1  single-cycle pulse, already debounced and edge-detected upstream.
- clear  in  1  synchronous single-cycle pulse.
- preset  in  W  BCD start value for timer.
- limit  in  W  BCD end value for stopwatch.
- digits  out  W  current BCD count; digit 0 = bits [3:0].
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on RUN->DONE.
- tick  out  1  one-cycle pulse on every count update.

Behaviour:
Reset (async assert, sync release):
- state=IDLE, digits=0, prescaler=0, done=0, tick=0, latched mode=0.

Nibble clamping:
- Any preset/limit nibble >9 is treated as 9 when used.
- In IDLE, digits shows 0 when mode=0 and clamped preset when mode=1. This is a registered update, so it follows mode/preset one cycle late.

IDLE:
- start_stop: latch mode; prescaler=0.
  - If the start value (0 for up, preset for down) already equals the end value (clamped limit for up, 0 for down): go to DONE and pulse done.
  - Otherwise go to RUN. digits holds the start value.

RUN:
- Prescaler counts 0..DIV-1. On the edge where it wraps to 0: tick=1, digits steps ±1 with per-digit BCD carry/borrow (9->0 carries, 0->9 borrows).
- First tick occurs DIV clocks after the start edge.
- If the new value equals the end value: same edge state=DONE, done=1 for one cycle.
- start_stop: go to PAUSE. Prescaler is frozen, not reset, so resume continues the partial second.
- Changes on mode/preset/limit are ignored.
- A limit below the start value is never reached; up-count then wraps 99..9 -> 00..0 and continues (documented, not an error).

PAUSE:
- digits and prescaler hold; start_stop returns to RUN.

DONE:
- digits holds the end value. start_stop or clear goes to IDLE.

clear (any state):
- Next state IDLE; prescaler=0; digits reloads its IDLE value.
- clear wins over a simultaneous start_stop or tick.
- A simultaneous tick is suppressed; done is not raised.

Simultaneous start_stop and tick in RUN:
- The tick is applied first, then the state goes to PAUSE.
- If that tick reaches the end value, DONE takes priority over PAUSE.

Reset mid-operation:
- Immediate return to reset values; no done pulse.

Outputs:
- All outputs registered; no combinational path from input to output.

Decomposition:
- Package crono_pkg: state encoding constants (IDLE/RUN/PAUSE/DONE), a BCD digit width constant of 4, and a clamp-nibble function.
- One sub-module, bcd_updown_counter, parametrised by DIGITS. Ports: clk, reset, load, load_val, step, dir; outputs value and match (value == compare input).
- Control FSM and prescaler live in crono_temp_core.

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10; DIGITS=4):
- Stopwatch, limit=0012, start -> tick every 10 clocks, digits 0000..0009, 0010, 0011, 0012; done high exactly one cycle at the 12th tick; state=DONE; digits stays 0012.
- Timer, preset=0100, start -> first tick gives 0099 (borrow across two digits); after 100 ticks digits=0000, done pulse, state=DONE.
- Pause/resume: start stopwatch, pause 5 clocks after tick 3 -> digits holds 0003 for 40 paused clocks; after resume the next tick comes exactly 5 clocks later.
- Edge cases: timer with preset=0000 -> start goes straight to DONE with a done pulse and no tick. Preset=00A5 is clamped and shows 0095.
- clear together with the terminal tick -> state=IDLE, no done pulse, digits reloaded to the IDLE value.
- Reset asserted mid-RUN at digits=0007 -> all outputs go to reset values immediately; after release, state=IDLE.

Source files
------------

// File: rtl/crono_pkg.sv
// Shared definitions for the crono stopwatch/timer core: state encoding,
// BCD digit width and nibble clamping.
package crono_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } crono_state_t;

   // Digits above 9 from the switch layer are treated as 9.
   function automatic logic [BCD_W-1:0] clamp_nibble(input logic [BCD_W-1:0] n);
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

endpackage

// File: rtl/bcd_updown_counter.sv
// Packed-BCD up/down counter with load. match compares the value about to be
// written (load/step applied) against cmp, so the caller sees hits on the same edge.
module bcd_updown_counter
   import crono_pkg::*;
#(
   parameter int DIGITS = 4,
   localparam int W = BCD_W * DIGITS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         step,
   input  logic         dir,
   input  logic [W-1:0] cmp,
   output logic [W-1:0] value,
   output logic         match
);

   logic [W-1:0]     value_q;
   logic [W-1:0]     value_d;
   logic [W-1:0]     stepped;
   logic             carry;
   logic [BCD_W-1:0] nib;

   // dir=0 counts up with 9->0 carry, dir=1 counts down with 0->9 borrow.
   always_comb begin
      stepped = value_q;
      carry   = 1'b1;
      nib     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         nib = value_q[i*BCD_W +: BCD_W];
         if (carry) begin
            if (!dir) begin
               if (nib >= 4'd9) begin
                  stepped[i*BCD_W +: BCD_W] = 4'd0;
               end else begin
                  stepped[i*BCD_W +: BCD_W] = nib + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (nib == 4'd0) begin
                  stepped[i*BCD_W +: BCD_W] = 4'd9;
               end else begin
                  stepped[i*BCD_W +: BCD_W] = nib - 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (step) begin
         value_d = stepped;
      end
   end

   assign match = (value_d == cmp);
   assign value = value_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/crono_temp_core.sv
// Stopwatch / countdown-timer core: tick prescaler, control FSM and BCD counter.
//   state | meaning
//   IDLE  | digits track idle value (0 or clamped preset); wait for start
//   RUN   | prescaler running, digits step once per tick
//   PAUSE | prescaler and digits frozen
//   DONE  | end value reached, digits hold it
module crono_temp_core
   import crono_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1,
   parameter int DIGITS  = 4,
   localparam int W = BCD_W * DIGITS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         mode,
   input  logic         start_stop,
   input  logic         clear,
   input  logic [W-1:0] preset,
   input  logic [W-1:0] limit,
   output logic [W-1:0] digits,
   output logic [1:0]   state,
   output logic         running,
   output logic         done,
   output logic         tick
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);

   generate
      if (DIV < 2) begin : g_div_check
         $error("crono_temp_core: CLK_HZ/TICK_HZ must be at least 2");
      end
   endgenerate

   crono_state_t state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          mode_q, mode_d;
   logic [W-1:0]  end_q, end_d;
   logic          done_q, done_d;
   logic          tick_q, tick_d;

   logic [W-1:0]  preset_c, limit_c;
   logic [W-1:0]  idle_val, idle_end, cmp_val;
   logic          load, step, dir, match;
   logic          presc_wrap;

   always_comb begin
      preset_c = '0;
      limit_c  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         preset_c[i*BCD_W +: BCD_W] = clamp_nibble(preset[i*BCD_W +: BCD_W]);
         limit_c[i*BCD_W +: BCD_W]  = clamp_nibble(limit[i*BCD_W +: BCD_W]);
      end
   end

   assign idle_val   = mode ? preset_c : '0;
   assign idle_end   = mode ? '0 : limit_c;
   // Live inputs only matter in IDLE; afterwards the latched copies are used.
   assign cmp_val    = (state_q == ST_IDLE) ? idle_end : end_q;
   assign dir        = (state_q == ST_IDLE) ? mode : mode_q;
   assign presc_wrap = (presc_q == PW'(DIV - 1));

   bcd_updown_counter #(.DIGITS(DIGITS)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (idle_val),
      .step     (step),
      .dir      (dir),
      .cmp      (cmp_val),
      .value    (digits),
      .match    (match)
   );

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      mode_d  = mode_q;
      end_d   = end_q;
      done_d  = 1'b0;
      tick_d  = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         presc_d = '0;
         load    = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               load = 1'b1;
               if (start_stop) begin
                  mode_d  = mode;
                  end_d   = idle_end;
                  presc_d = '0;
                  if (match) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (presc_wrap) begin
                  presc_d = '0;
                  step    = 1'b1;
                  tick_d  = 1'b1;
                  if (match) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else if (start_stop) begin
                     state_d = ST_PAUSE;
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
                  if (start_stop) state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start_stop) state_d = ST_RUN;
            end
            ST_DONE: begin
               if (start_stop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         mode_q  <= 1'b0;
         end_q   <= '0;
         done_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         mode_q  <= mode_d;
         end_q   <= end_d;
         done_q  <= done_d;
         tick_q  <= tick_d;
      end
   end

   assign state   = state_q;
   assign running = (state_q == ST_RUN);
   assign done    = done_q;
   assign tick    = tick_q;

endmodule
